alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Command-driven initiator for the 8-bit combinational ALU. It accepts multi-cycle operation commands over a valid/ready handshake and reads operands from a small internal register file. It issues one ALU opcode per cycle for a programmable number of iterations (for example, shift-by-N built from single-bit shifts, or repeated add), then writes the result back and returns a response. It sits between the host/control logic and an external ALU instance; the ALU's `c/A/B/s/cout` pins connect directly to the `alu_*` ports.

## Interface
- `NREG`, 4: register-file depth; `AW = $clog2(NREG)`.
- `CNT_W`, 3: iteration-count width; iterations per command = `cmd_cnt + 1`.

Clock and reset: one clock; reset is asynchronous and active-low.

- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_op`  in  4  ALU opcode.
- `cmd_dst` / `cmd_srca` / `cmd_srcb`  in  AW each  destination and source register indices.
- `cmd_cnt`  in  CNT_W  iteration count minus one.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed.
- `rsp_data`  out  8  final result.
- `rsp_carry`  out  1  carry of the final iteration.
- `rsp_err`  out  1  illegal opcode.
- `wr_en` / `wr_addr` (AW) / `wr_data` (8)  in  host register preload port.
- `alu_c`  out  4  opcode to the ALU.
- `alu_a` / `alu_b`  out  8 each  operands to the ALU.
- `alu_s`  in  8  ALU result.
- `alu_cout`  in  1  ALU carry.

## Operation
- **Legal opcodes:**
  - 1 add, 2 inc, 3 sub, 4 dec.
  - 6 signed min, 7 signed max.
  - 8 ror, 9 rol.
  - A lsr, B lsl, C asr.
  - D lsl with bit-0 fill.
  - All other values are illegal. The ALU output is undefined for them, so they are never issued.
- **FSM states:** IDLE, EXEC, RESP.
- **IDLE:**
  - `cmd_ready`=1.
  - On `cmd_valid && cmd_ready`, latch `op/dst/cnt` and latch operands `work=reg[srca]`, `opb=reg[srcb]`.
  - Legal op → EXEC with `iter=0`.
  - Illegal op → RESP with `rsp_err`=1, `rsp_data`=0, `rsp_carry`=0, no write.
- **EXEC:**
  - Drive `alu_c=op`, `alu_a=work`, `alu_b=opb`.
  - Each edge: `work<=alu_s`, `carry<=alu_cout` for ops 1–4, otherwise `carry<=0`.
  - If `iter==cnt`: write `reg[dst]<=alu_s` and go to RESP. Otherwise `iter<=iter+1`.
- **RESP:**
  - `rsp_valid`=1; `rsp_data`, `rsp_carry`, `rsp_err` held stable.
  - On `rsp_ready` → IDLE.
- **Outside EXEC:** `alu_c`=0, `alu_a`=0, `alu_b`=0.
- **Host write port:**
  - Accepted in any state.
  - Operands are latched at accept, so host writes to `srca`/`srcb` during EXEC do not affect the running command.
  - A host write to `dst` in the same cycle as the final EXEC write: the sequencer write wins.
- **Arithmetic:** all datapath values are 8 bits and wrap mod 256. Carry is exactly the ALU `cout` of the last iteration.

## Timing
- **Latency:**
  - Accept at edge T. EXEC occupies cycles T+1 … T+1+cnt.
  - `rsp_valid` is high from cycle T+cnt+2.
  - The register-file write lands at the same edge that enters RESP.
- **Illegal opcode:** `rsp_valid` is high from cycle T+1.
- **Back-to-back:** `cmd_ready` rises the cycle after the `rsp_valid && rsp_ready` edge. The sequencer never overlaps commands.
- **Reset values** while `rst_n`=0, and immediately on assertion, including mid-EXEC:
  - State IDLE; all registers 0.
  - `cmd_ready`=0 during reset, 1 at the first cycle after release.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_carry`=0, `rsp_err`=0.
  - `alu_c`=0, `alu_a`=0, `alu_b`=0.
  - Any in-flight command is discarded.
- **Backpressure:** `rsp_valid` and response fields remain stable until `rsp_ready`. `cmd_valid` is ignored while not ready.

## Structure
- **Package `alu_pkg`:**
  - `alu_op_t` enum with the 4-bit opcodes above.
  - `alu_op_legal()` function.
  - `alu_op_has_carry()` function (ops 1–4).
  - FSM state typedef.
- **Sub-module `alu_seq_regfile`:**
  - NREG×8 registers, async-reset to 0.
  - Two combinational read ports.
  - One write port with priority sequencer > host.
- The ALU itself stays external.

## Test plan
- **Single add:** preload R0=0x05, R1=0x03; cmd op=1 dst=2 a=0 b=1 cnt=0 → `alu_c`=1 for one cycle; `rsp_valid` at T+2 with data 0x08, carry 0, err 0; R2=0x08.
- **Repeated shift:** preload R0=0x81; cmd op=A dst=0 a=0 cnt=2 → three EXEC cycles with `alu_a` 0x81, 0x40, 0x20; response 0x10, carry 0; R0=0x10.
- **Repeated add with carry:** R0=0xF0, R1=0x10; op=1 cnt=1 → iteration 1 gives 0x00 with cout 1, iteration 2 gives 0x10 with cout 0; response 0x10, carry 0.
- **Illegal opcode:** op=5 → `rsp_err`=1, data 0x00 at T+1; `alu_c` stays 0; no register changes.
- **Backpressure and hazards:** hold `rsp_ready`=0 for 3 cycles → response stable, `cmd_ready`=0, extra `cmd_valid` ignored. A host write to `dst` on the final EXEC cycle → sequencer value retained.
- **Reset mid-operation:** assert `rst_n`=0 mid-EXEC of a cnt=7 command → all outputs and registers 0 immediately; no response issued; `cmd_ready`=1 the first cycle after release.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_pkg: ALU opcode encoding, legality/carry helpers, sequencer states. Rev 1.0
// ----------------------------------------------------------------------------
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'h1,
    OP_INC  = 4'h2,
    OP_SUB  = 4'h3,
    OP_DEC  = 4'h4,
    OP_MIN  = 4'h6,
    OP_MAX  = 4'h7,
    OP_ROR  = 4'h8,
    OP_ROL  = 4'h9,
    OP_LSR  = 4'hA,
    OP_LSL  = 4'hB,
    OP_ASR  = 4'hC,
    OP_LSL1 = 4'hD
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seq_state_t;

  // Opcodes the external ALU defines a result for; anything else is never issued.
  function automatic logic alu_op_legal(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_INC, OP_SUB, OP_DEC,
      OP_MIN, OP_MAX,
      OP_ROR, OP_ROL,
      OP_LSR, OP_LSL, OP_ASR, OP_LSL1: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  function automatic logic alu_op_has_carry(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_INC) || (op == OP_SUB) || (op == OP_DEC);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_op_sequencer_if: command and response channels of the sequencer. Rev 1.0
// ----------------------------------------------------------------------------
interface alu_op_sequencer_if #(
  parameter int AW    = 2,
  parameter int CNT_W = 3
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [AW-1:0]    cmd_dst;
  logic [AW-1:0]    cmd_srca;
  logic [AW-1:0]    cmd_srcb;
  logic [CNT_W-1:0] cmd_cnt;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_data;
  logic             rsp_carry;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_cnt,
    input  cmd_ready,
    input  rsp_valid, rsp_data, rsp_carry, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_cnt,
    output cmd_ready,
    output rsp_valid, rsp_data, rsp_carry, rsp_err,
    input  rsp_ready
  );

endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer_regfile.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_seq_regfile: NREG x 8 operand registers, two read ports, one merged write. Rev 1.0
// ----------------------------------------------------------------------------
module alu_seq_regfile #(
  parameter int NREG = 4,
  parameter int AW   = $clog2(NREG)
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic [AW-1:0] rd_addr_a,
  input  wire logic [AW-1:0] rd_addr_b,
  output logic      [7:0]    rd_data_a,
  output logic      [7:0]    rd_data_b,
  input  wire logic          seq_we,
  input  wire logic [AW-1:0] seq_addr,
  input  wire logic [7:0]    seq_data,
  input  wire logic          host_we,
  input  wire logic [AW-1:0] host_addr,
  input  wire logic [7:0]    host_data
);

  logic [7:0] regs [NREG];

  // Priority is resolved per register so a host write to a different
  // index in the same cycle as a sequencer write-back is still taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (seq_we && (seq_addr == AW'(i))) begin
          regs[i] <= seq_data;
        end else if (host_we && (host_addr == AW'(i))) begin
          regs[i] <= host_data;
        end
      end
    end
  end

  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_op_sequencer: iterates one ALU opcode over latched operands, writes back, responds. Rev 1.0
// ----------------------------------------------------------------------------
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int NREG  = 4,
  parameter int AW    = $clog2(NREG),
  parameter int CNT_W = 3
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  alu_op_sequencer_if.slave     cmd_bus,
  input  wire logic             wr_en,
  input  wire logic [AW-1:0]    wr_addr,
  input  wire logic [7:0]       wr_data,
  output logic      [3:0]       alu_c,
  output logic      [7:0]       alu_a,
  output logic      [7:0]       alu_b,
  input  wire logic [7:0]       alu_s,
  input  wire logic             alu_cout
);

  seq_state_t       state;
  logic [AW-1:0]    dst_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] iter_q;
  logic [3:0]       op_q;
  logic [7:0]       work_q;
  logic [7:0]       opb_q;

  logic             cmd_ready_q;
  logic             rsp_valid_q;
  logic [7:0]       rsp_data_q;
  logic             rsp_carry_q;
  logic             rsp_err_q;

  logic [7:0]       rd_a;
  logic [7:0]       rd_b;
  logic             last_iter;
  logic             seq_we;

  assign last_iter = (iter_q == cnt_q);
  assign seq_we    = (state == ST_EXEC) && last_iter;

  alu_seq_regfile #(
    .NREG (NREG),
    .AW   (AW)
  ) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (cmd_bus.cmd_srca),
    .rd_addr_b (cmd_bus.cmd_srcb),
    .rd_data_a (rd_a),
    .rd_data_b (rd_b),
    .seq_we    (seq_we),
    .seq_addr  (dst_q),
    .seq_data  (alu_s),
    .host_we   (wr_en),
    .host_addr (wr_addr),
    .host_data (wr_data)
  );

  // op_q/work_q/opb_q double as the ALU drive registers: they hold the
  // command only while in EXEC and are zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      dst_q       <= '0;
      cnt_q       <= '0;
      iter_q      <= '0;
      op_q        <= '0;
      work_q      <= '0;
      opb_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_bus.cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            dst_q       <= cmd_bus.cmd_dst;
            cnt_q       <= cmd_bus.cmd_cnt;
            iter_q      <= '0;
            if (alu_op_legal(cmd_bus.cmd_op)) begin
              state  <= ST_EXEC;
              op_q   <= cmd_bus.cmd_op;
              work_q <= rd_a;
              opb_q  <= rd_b;
            end else begin
              state       <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
              rsp_carry_q <= 1'b0;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end

        ST_EXEC: begin
          if (last_iter) begin
            state       <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= alu_s;
            rsp_carry_q <= alu_op_has_carry(op_q) ? alu_cout : 1'b0;
            rsp_err_q   <= 1'b0;
            op_q        <= '0;
            work_q      <= '0;
            opb_q       <= '0;
          end else begin
            work_q <= alu_s;
            iter_q <= iter_q + CNT_W'(1);
          end
        end

        ST_RESP: begin
          if (cmd_bus.rsp_ready) begin
            state       <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_err_q   <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_bus.cmd_ready = cmd_ready_q;
  assign cmd_bus.rsp_valid = rsp_valid_q;
  assign cmd_bus.rsp_data  = rsp_data_q;
  assign cmd_bus.rsp_carry = rsp_carry_q;
  assign cmd_bus.rsp_err   = rsp_err_q;

  assign alu_c = op_q;
  assign alu_a = work_q;
  assign alu_b = opb_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_alu_op_sequencer: directed scoreboard bench with a behavioural ALU. Rev 1.0
// ----------------------------------------------------------------------------
module tb_alu_op_sequencer;

  typedef struct {
    logic [7:0] data;
    logic       carry;
    logic       err;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] alu_c;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_s;
  logic       alu_cout;

  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];
  logic [7:0] model [4];
  logic [7:0] trace_a [8];
  logic [3:0] trace_c [8];
  int         trace_n;

  alu_op_sequencer_if #(.AW(2), .CNT_W(3)) ifc ();

  alu_op_sequencer #(.NREG(4), .AW(2), .CNT_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_bus  (ifc),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .alu_c    (alu_c),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_s    (alu_s),
    .alu_cout (alu_cout)
  );

  always #5 clk = ~clk;

  // Reference ALU: {cout, s}. Shifts report the shifted-out bit as cout so the
  // sequencer's carry masking for non-arithmetic ops is observable.
  function automatic logic [8:0] alu_fn(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    case (c)
      4'h1: return {1'b0, a} + {1'b0, b};
      4'h2: return {1'b0, a} + 9'd1;
      4'h3: return {1'b0, a} - {1'b0, b};
      4'h4: return {1'b0, a} - 9'd1;
      4'h6: return {1'b0, (($signed(a) < $signed(b)) ? a : b)};
      4'h7: return {1'b0, (($signed(a) > $signed(b)) ? a : b)};
      4'h8: return {a[0], a[0], a[7:1]};
      4'h9: return {a[7], a[6:0], a[7]};
      4'hA: return {a[0], 1'b0, a[7:1]};
      4'hB: return {a[7], a[6:0], 1'b0};
      4'hC: return {a[0], a[7], a[7:1]};
      4'hD: return {a[7], a[6:0], 1'b1};
      default: return 9'h000;
    endcase
  endfunction

  function automatic logic op_legal(input logic [3:0] op);
    return (op >= 4'h1 && op <= 4'h4) || (op >= 4'h6 && op <= 4'hD);
  endfunction

  assign {alu_cout, alu_s} = alu_fn(alu_c, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_r%0d", tag, i), {24'd0, dut.u_rf.regs[i]}, {24'd0, model[i]});
    end
  endtask

  task automatic host_write(input logic [1:0] addr, input logic [7:0] data);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    @(negedge clk);
    wr_en   = 1'b0;
    model[addr] = data;
  endtask

  task automatic send_cmd(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sa,
                          input logic [1:0] sbi, input logic [2:0] cnt);
    exp_t       e;
    logic [7:0] w;
    logic [8:0] r;
    int         n;
    n = 0;
    w = model[sa];
    r = 9'h000;
    if (op_legal(op)) begin
      for (int i = 0; i <= int'(cnt); i++) begin
        r = alu_fn(op, w, model[sbi]);
        w = r[7:0];
      end
      e.data  = w;
      e.carry = (op >= 4'h1 && op <= 4'h4) ? r[8] : 1'b0;
      e.err   = 1'b0;
      e.lat   = int'(cnt) + 1;
      model[dst] = w;
    end else begin
      e.data  = 8'h00;
      e.carry = 1'b0;
      e.err   = 1'b1;
      e.lat   = 0;
    end
    sb.push_back(e);
    @(negedge clk);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = op;
    ifc.cmd_dst   = dst;
    ifc.cmd_srca  = sa;
    ifc.cmd_srcb  = sbi;
    ifc.cmd_cnt   = cnt;
    while (!ifc.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept_timeout", n < 20, 1);
    @(posedge clk);
    #1;
    ifc.cmd_valid = 1'b0;
  endtask

  // Collects the ALU drive per cycle until the response, compares against the
  // scoreboard head, optionally stalls rsp_ready and injects one host write.
  task automatic wait_rsp(input int hold, input int hz_k, input logic [1:0] hz_addr, input logic [7:0] hz_data);
    exp_t e;
    int   k;
    k = 0;
    trace_n = 0;
    @(negedge clk);
    while (!ifc.rsp_valid && k < 40) begin
      if (trace_n < 8) begin
        trace_c[trace_n] = alu_c;
        trace_a[trace_n] = alu_a;
        trace_n++;
      end
      if (k == hz_k) begin
        wr_en = 1'b1; wr_addr = hz_addr; wr_data = hz_data;
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    wr_en = 1'b0;
    chk("rsp_timeout", k < 40, 1);
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk("rsp_latency", k, e.lat);
    chk("rsp_data", ifc.rsp_data, e.data);
    chk("rsp_carry", ifc.rsp_carry, e.carry);
    chk("rsp_err", ifc.rsp_err, e.err);
    chk("alu_c_in_resp", alu_c, 0);
    for (int h = 0; h < hold; h++) begin
      ifc.cmd_valid = 1'b1;
      ifc.cmd_op    = 4'h1;
      @(negedge clk);
      chk("bp_valid", ifc.rsp_valid, 1);
      chk("bp_data", ifc.rsp_data, e.data);
      chk("bp_cmd_ready", ifc.cmd_ready, 0);
    end
    ifc.cmd_valid = 1'b0;
    ifc.rsp_ready = 1'b1;
    @(negedge clk);
    ifc.rsp_ready = 1'b0;
    chk("post_hs_valid", ifc.rsp_valid, 0);
    chk("post_hs_cmd_ready", ifc.cmd_ready, 1);
  endtask

  initial begin
    rst_n         = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op    = '0;
    ifc.cmd_dst   = '0;
    ifc.cmd_srca  = '0;
    ifc.cmd_srcb  = '0;
    ifc.cmd_cnt   = '0;
    ifc.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", ifc.cmd_ready, 0);
    chk("rst_rsp_valid", ifc.rsp_valid, 0);
    chk("rst_alu_c", alu_c, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_cmd_ready", ifc.cmd_ready, 1);

    // Single add
    host_write(2'd0, 8'h05);
    host_write(2'd1, 8'h03);
    send_cmd(4'h1, 2'd2, 2'd0, 2'd1, 3'd0);
    wait_rsp(0, -1, 2'd0, 8'h00);
    chk("add_trace_n", trace_n, 1);
    chk("add_alu_c", trace_c[0], 4'h1);
    chk_regs("add");

    // Repeated logical shift right
    host_write(2'd0, 8'h81);
    send_cmd(4'hA, 2'd0, 2'd0, 2'd0, 3'd2);
    wait_rsp(0, -1, 2'd0, 8'h00);
    chk("lsr_a0", trace_a[0], 8'h81);
    chk("lsr_a1", trace_a[1], 8'h40);
    chk("lsr_a2", trace_a[2], 8'h20);
    chk_regs("lsr");

    // Repeated add crossing the carry
    host_write(2'd0, 8'hF0);
    host_write(2'd1, 8'h10);
    send_cmd(4'h1, 2'd3, 2'd0, 2'd1, 3'd1);
    wait_rsp(0, -1, 2'd0, 8'h00);
    chk("radd_a1", trace_a[1], 8'h00);
    chk_regs("radd");

    // Shift whose ALU cout is 1 must still report carry 0
    host_write(2'd2, 8'h81);
    send_cmd(4'hB, 2'd1, 2'd2, 2'd2, 3'd0);
    wait_rsp(0, -1, 2'd0, 8'h00);

    // Subtract with borrow, signed max
    host_write(2'd0, 8'h10);
    host_write(2'd1, 8'h20);
    send_cmd(4'h3, 2'd2, 2'd0, 2'd1, 3'd0);
    wait_rsp(0, -1, 2'd0, 8'h00);
    host_write(2'd0, 8'h80);
    host_write(2'd1, 8'h05);
    send_cmd(4'h7, 2'd3, 2'd0, 2'd1, 3'd0);
    wait_rsp(0, -1, 2'd0, 8'h00);
    chk_regs("max");

    // Illegal opcodes
    send_cmd(4'h5, 2'd0, 2'd0, 2'd1, 3'd3);
    chk("ill_alu_c", alu_c, 0);
    wait_rsp(0, -1, 2'd0, 8'h00);
    send_cmd(4'hF, 2'd1, 2'd0, 2'd1, 3'd0);
    wait_rsp(0, -1, 2'd0, 8'h00);
    chk_regs("ill");

    // Backpressure plus host write to dst on the final EXEC cycle
    host_write(2'd1, 8'h41);
    send_cmd(4'h2, 2'd1, 2'd1, 2'd1, 3'd1);
    wait_rsp(3, 1, 2'd1, 8'hEE);
    chk_regs("hz");

    // Reset in the middle of a long command
    send_cmd(4'h2, 2'd0, 2'd3, 2'd3, 3'd7);
    repeat (3) @(negedge clk);
    chk("mid_alu_c", alu_c, 4'h2);
    rst_n = 1'b0;
    #1;
    chk("mr_alu_c", alu_c, 0);
    chk("mr_alu_a", alu_a, 0);
    chk("mr_alu_b", alu_b, 0);
    chk("mr_rsp_valid", ifc.rsp_valid, 0);
    chk("mr_cmd_ready", ifc.cmd_ready, 0);
    sb.delete();
    for (int i = 0; i < 4; i++) model[i] = 8'h00;
    chk_regs("mr");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_rel_cmd_ready", ifc.cmd_ready, 1);
    chk("mr_rel_rsp_valid", ifc.rsp_valid, 0);
    send_cmd(4'h1, 2'd2, 2'd0, 2'd1, 3'd0);
    wait_rsp(0, -1, 2'd0, 8'h00);
    chk_regs("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
